// File: rtl/uart_1318_pkg.sv
// Shared types, constants and helpers for the 1318 UART link (rx and tx).
// The PARITY state only exists when UART_RX_1318_PARITY_EN is defined.
package uart_1318_pkg;

  localparam int unsigned DATA_BITS        = 8;
  localparam int unsigned BAUD_DIV_DEFAULT = 16;

  typedef enum logic [2:0] {
    WAIT_HIGH = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
`ifdef UART_RX_1318_PARITY_EN
    PARITY    = 3'd4,
`endif
    STOP      = 3'd5
  } rx_state_t;

  // Even-parity bit for a data word: 1 when the word has an odd number of ones.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_frame_1318_if.sv
// Receive-side bus of the 1318 UART: serial line in, accepted byte and strobes out.
interface uart_rx_frame_1318_if;
  import uart_1318_pkg::*;

  logic                 RX_In;
  logic [DATA_BITS-1:0] DATA_RX_Out;
  logic                 Ok_Data_Rx;
  logic                 Frame_Err;
  logic                 Parity_Err;

  modport master (
    input  RX_In,
    output DATA_RX_Out, Ok_Data_Rx, Frame_Err, Parity_Err
  );

  modport slave (
    output RX_In,
    input  DATA_RX_Out, Ok_Data_Rx, Frame_Err, Parity_Err
  );
endinterface

// File: rtl/uart_sync_1318.sv
// Two-flop synchronizer for asynchronous inputs; reset value is a parameter.
module uart_sync_1318 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_frame_1318.sv
// 1318 UART receiver: 8N1 frames, or 8E1 when UART_RX_1318_PARITY_EN is defined.
// Each bit is sampled mid-period; accepted bytes are presented with a one-cycle strobe.
module uart_rx_frame_1318
  import uart_1318_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input logic                   Clk_RX,
  input logic                   Reset_R,
  uart_rx_frame_1318_if.master  rx_bus
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIV/2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic rxs;

  uart_sync_1318 #(.RESET_VAL(1'b1)) u_sync (
    .clk_i (Clk_RX),
    .rst_i (Reset_R),
    .d_i   (rx_bus.RX_In),
    .q_o   (rxs)
  );

  rx_state_t            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [BIT_W-1:0]     bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 ok_q;
  logic                 ferr_q;
`ifdef UART_RX_1318_PARITY_EN
  logic                 perr_q;
  logic                 mism_q;
`endif

  // Frame FSM; strobes default low every cycle so they last exactly one cycle.
  always_ff @(posedge Clk_RX) begin
    if (Reset_R) begin
      state_q <= WAIT_HIGH;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ok_q    <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_1318_PARITY_EN
      perr_q  <= 1'b0;
      mism_q  <= 1'b0;
`endif
    end else begin
      ok_q   <= 1'b0;
      ferr_q <= 1'b0;
`ifdef UART_RX_1318_PARITY_EN
      perr_q <= 1'b0;
`endif
      case (state_q)
        WAIT_HIGH: begin
          if (rxs) state_q <= IDLE;
        end
        IDLE: begin
          if (!rxs) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= rxs ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
            bit_q   <= bit_q + BIT_W'(1);
            if (bit_q == LAST_BIT) begin
`ifdef UART_RX_1318_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`ifdef UART_RX_1318_PARITY_EN
        PARITY: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            mism_q  <= (rxs != even_parity(shift_q));
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          // Leaving mid-stop-bit lets a start edge right after the stop bit be caught.
          if (cnt_q == FULL_M1) begin
            cnt_q <= '0;
            if (rxs) begin
              data_q  <= shift_q;
              ok_q    <= 1'b1;
`ifdef UART_RX_1318_PARITY_EN
              perr_q  <= mism_q;
`endif
              state_q <= IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= WAIT_HIGH;
      endcase
    end
  end

  assign rx_bus.DATA_RX_Out = data_q;
  assign rx_bus.Ok_Data_Rx  = ok_q;
  assign rx_bus.Frame_Err   = ferr_q;
`ifdef UART_RX_1318_PARITY_EN
  assign rx_bus.Parity_Err  = perr_q;
`else
  assign rx_bus.Parity_Err  = 1'b0;
`endif

endmodule

// File: doc/uart_rx_frame_1318.md
# uart_rx_frame_1318

Serial receiver for the 1318 UART link. Recovers 8N1 frames (8E1 when parity is compiled in) from an asynchronous line driven by the team's UART transmitter, and presents each accepted byte with a one-cycle ready strobe. It sits on the receive side of the UART top, fed directly by the transmitter's serial output or an external pin. It runs on the receive clock only.

## Interface
- BAUD_DIV, 16: clock cycles per bit period; even, ≥ 4.
- Clk_RX  input  1  receive clock; all logic on rising edge.
- Reset_R  input  1  synchronous reset, active-high.
- RX_In  input  1  asynchronous serial line; idle high.
- DATA_RX_Out  output  8  last accepted byte; held until the next accepted frame.
- Ok_Data_Rx  output  1  one-cycle pulse: DATA_RX_Out updated this cycle.
- Frame_Err  output  1  one-cycle pulse: stop bit sampled low, byte discarded.
- Parity_Err  output  1  one-cycle pulse with Ok_Data_Rx on even-parity mismatch; constant 0 without parity.

## Operation
- RX_In passes through a 2-FF synchronizer (flops reset to 1); all decisions use the synchronized value `rxs`.
- FSM states: WAIT_HIGH, IDLE, START, DATA, PARITY, STOP.
- WAIT_HIGH: entered on reset and after a frame error. Go to IDLE on the first cycle with rxs = 1.
- IDLE: on rxs = 0, go to START and clear the bit counter `cnt`.
- START: when `cnt` = BAUD_DIV/2−1, sample mid-bit.
  - Sample 0: go to DATA.
  - Sample 1: glitch; go to IDLE silently.
- DATA: sample every BAUD_DIV cycles. Shift LSB first into an 8-bit register. After bit 7, go to PARITY if enabled, otherwise STOP.
- PARITY: sample one bit and record mismatch = (sampled bit ≠ XOR of data bits).
- STOP: sample one bit.
  - Sample 1: load DATA_RX_Out, pulse Ok_Data_Rx (and Parity_Err if mismatch), go to IDLE.
  - Sample 0: pulse Frame_Err, keep DATA_RX_Out unchanged, go to WAIT_HIGH.
- `cnt` width is $clog2(BAUD_DIV). It restarts at 0 on every sample and never wraps mid-bit.
- Back-to-back frames: IDLE is re-entered half a bit before the stop bit ends. A start edge arriving immediately after the stop bit must be caught.
- Reset mid-frame: the partial frame is discarded, no strobe is issued, and the FSM enters WAIT_HIGH. A line held low through reset never produces a byte.

## Timing
- Reset values: DATA_RX_Out = 8'h00, Ok_Data_Rx = 0, Frame_Err = 0, Parity_Err = 0, state = WAIT_HIGH.
- Edge 0 is the first clock edge that samples RX_In low while in IDLE with the line previously high. START is entered at edge 2.
- Start validation sample: edge 2 + BAUD_DIV/2.
- Data bit k (k = 0..7) sample: edge 2 + BAUD_DIV/2 + (k+1)·BAUD_DIV.
- Stop sample: edge 2 + BAUD_DIV/2 + 9·BAUD_DIV, plus BAUD_DIV with parity.
- All outputs are registered. Strobes are high for exactly one cycle, starting the cycle after the stop sample edge.
- Latency, BAUD_DIV = 16, no parity: Ok_Data_Rx is high in the cycle after edge 154.
- No back-pressure. The consumer must take DATA_RX_Out before the next Ok_Data_Rx; it is overwritten without warning.

## Configuration
- UART_RX_1318_PARITY_EN defined:
  - PARITY state is present and the frame is 8E1.
  - Parity_Err is live.
  - Stop sample moves one bit later.
- UART_RX_1318_PARITY_EN undefined:
  - Frame is 8N1 and the PARITY state is absent.
  - Parity_Err is tied to 0.
  - The port list is identical in both builds.

## Structure
- Package uart_1318_pkg:
  - state enum (rx_state_t);
  - DATA_BITS = 8;
  - default BAUD_DIV;
  - a parity-function helper.
  - The transmitter shares the package.
- Sub-module uart_sync_1318: parameterizable-reset 2-FF synchronizer. It is reused for Start and other async inputs elsewhere.

## Test plan
- Reset, then RX_In idle high for 200 cycles -> all outputs 0, no strobes.
- Send 8'hA5 8N1 at BAUD_DIV = 16 -> single Ok_Data_Rx pulse in the cycle after edge 154, DATA_RX_Out = 8'hA5, Frame_Err = 0.
- Drive a 4-cycle low glitch on RX_In, then send 8'h3C -> glitch ignored, exactly one Ok_Data_Rx with 8'h3C.
- Send 8'h00 with the stop bit forced low and hold the line low 40 cycles, then send 8'h81 -> Frame_Err pulse, DATA_RX_Out keeps its prior value, then Ok_Data_Rx with 8'h81.
- Send 8'h55, 8'hAA, 8'hFF with no idle gap -> three Ok_Data_Rx pulses in order, each exactly 10·BAUD_DIV cycles apart.
- With UART_RX_1318_PARITY_EN: send 8'h07 with parity bit 0 (wrong) -> Ok_Data_Rx and Parity_Err pulse together, DATA_RX_Out = 8'h07. Assert Reset_R mid-frame on the next frame -> no strobe, FSM in WAIT_HIGH.
